// File: rtl/heepsilon_pwr_seq_if.sv
// Request/status bundle between the software register bank, the power switches and the
// multi-channel power sequencer.
interface heepsilon_pwr_seq_if #(
  parameter int unsigned N_CH = 2
);
  logic [N_CH-1:0] on_req_i;
  logic [N_CH-1:0] off_req_i;
  logic [N_CH-1:0] sw_ack_i;
  logic [N_CH-1:0] err_clr_i;
  logic [N_CH-1:0] clk_en_o;
  logic [N_CH-1:0] iso_o;
  logic [N_CH-1:0] subsys_rst_o;
  logic [N_CH-1:0] sw_on_o;
  logic [N_CH-1:0] on_o;
  logic [N_CH-1:0] busy_o;
  logic [N_CH-1:0] done_o;
  logic [N_CH-1:0] err_o;
  logic            irq_o;

  modport master (
    output on_req_i, off_req_i, sw_ack_i, err_clr_i,
    input  clk_en_o, iso_o, subsys_rst_o, sw_on_o, on_o, busy_o, done_o, err_o, irq_o
  );

  modport slave (
    input  on_req_i, off_req_i, sw_ack_i, err_clr_i,
    output clk_en_o, iso_o, subsys_rst_o, sw_on_o, on_o, busy_o, done_o, err_o, irq_o
  );
endinterface

// File: rtl/heepsilon_pwr_seq.sv
// Per-channel clock/isolation/reset/power-switch sequencer for external subsystems.
// Optional power-switch ack timeout: define HEEPSILON_PWR_ACK_TIMEOUT_EN.
module heepsilon_pwr_seq #(
  parameter int unsigned N_CH        = 2,
  parameter int unsigned DLY         = 4,
  parameter int unsigned ACK_TIMEOUT = 256,
  parameter bit          INIT_ON     = 1'b1
) (
  input logic                clk_i,
  input logic                rst_i,
  heepsilon_pwr_seq_if.slave bus
);
  localparam int unsigned CW = $clog2(DLY + 1);
`ifdef HEEPSILON_PWR_ACK_TIMEOUT_EN
  localparam int unsigned TW = $clog2(ACK_TIMEOUT + 1);
`endif

  // Power control word: {clk_en, iso, subsys_rst, sw_on}
  localparam logic [3:0] PWR_ON  = 4'b1001;
  localparam logic [3:0] PWR_OFF = 4'b0110;

  typedef enum logic [3:0] {
    S_ON, S_CLK_OFF, S_ISO, S_RST, S_SW_OFF,
    S_OFF, S_SW_ON, S_CLK_ON, S_RST_REL, S_ISO_REL
  } state_e;

  logic [N_CH-1:0] done_d_v;
  logic [N_CH-1:0] err_d_v;
  logic [N_CH-1:0] err_q_v;
  logic            irq_q;

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          pend_q, pend_d;
    logic [3:0]    pwr_q, pwr_d;
    logic          on_q, on_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          err_q, err_d;
    logic          on_r, off_r, ack, tmo, stable, tgt_off;

    assign on_r    = bus.on_req_i[g];
    assign off_r   = bus.off_req_i[g];
    assign ack     = bus.sw_ack_i[g];
    assign stable  = (state_q == S_ON) || (state_q == S_OFF);
    assign tgt_off = (state_q == S_CLK_OFF) || (state_q == S_ISO) ||
                     (state_q == S_RST) || (state_q == S_SW_OFF);

`ifdef HEEPSILON_PWR_ACK_TIMEOUT_EN
    logic [TW-1:0] tcnt_q, tcnt_d;
    // Give up on the switch after ACK_TIMEOUT cycles in a wait state
    assign tmo = (tcnt_q == TW'(ACK_TIMEOUT - 1)) &&
                 (((state_q == S_SW_OFF) && ack) || ((state_q == S_SW_ON) && !ack));
`else
    assign tmo = 1'b0;
`endif

    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        if (INIT_ON) begin
          state_q <= S_ON;
          pwr_q   <= PWR_ON;
        end else begin
          state_q <= S_OFF;
          pwr_q   <= PWR_OFF;
        end
        cnt_q  <= '0;
        pend_q <= 1'b0;
        on_q   <= INIT_ON;
        busy_q <= 1'b0;
        done_q <= 1'b0;
        err_q  <= 1'b0;
`ifdef HEEPSILON_PWR_ACK_TIMEOUT_EN
        tcnt_q <= '0;
`endif
      end else begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
        pend_q  <= pend_d;
        pwr_q   <= pwr_d;
        on_q    <= on_d;
        busy_q  <= busy_d;
        done_q  <= done_d;
        err_q   <= err_d;
`ifdef HEEPSILON_PWR_ACK_TIMEOUT_EN
        tcnt_q  <= tcnt_d;
`endif
      end
    end

    always_comb begin
      state_d = state_q;
      cnt_d   = (cnt_q != '0) ? cnt_q - CW'(1) : cnt_q;
      pend_d  = pend_q;
      pwr_d   = pwr_q;
      err_d   = err_q;

      case (state_q)
        S_ON:      if (off_r || pend_q) state_d = S_CLK_OFF;
        S_CLK_OFF: if (cnt_q == '0) state_d = S_ISO;
        S_ISO:     if (cnt_q == '0) state_d = S_RST;
        S_RST:     if (cnt_q == '0) state_d = S_SW_OFF;
        S_SW_OFF:  if (!ack || tmo) state_d = S_OFF;
        S_OFF:     if (on_r || pend_q) state_d = S_SW_ON;
        S_SW_ON:   if (ack || tmo) state_d = S_CLK_ON;
        S_CLK_ON:  if (cnt_q == '0) state_d = S_RST_REL;
        S_RST_REL: if (cnt_q == '0) state_d = S_ISO_REL;
        S_ISO_REL: state_d = S_ON;
        default:   state_d = S_OFF;
      endcase

      // One-deep reversal request, consumed when the stable state is left
      if (stable) pend_d = 1'b0;
      else if (tgt_off ? on_r : off_r) pend_d = 1'b1;
      else if (tgt_off ? off_r : on_r) pend_d = 1'b0;

      if (state_d != state_q) cnt_d = CW'(DLY - 1);

      case (state_d)
        S_ON, S_ISO_REL: pwr_d = PWR_ON;
        S_CLK_OFF:       pwr_d = 4'b0001;
        S_ISO:           pwr_d = 4'b0101;
        S_RST:           pwr_d = 4'b0111;
        S_SW_OFF, S_OFF: pwr_d = PWR_OFF;
        S_SW_ON:         pwr_d = 4'b0111;
        S_CLK_ON:        pwr_d = 4'b1111;
        S_RST_REL:       pwr_d = 4'b1101;
        default:         pwr_d = pwr_q;
      endcase

      on_d   = (state_d == S_ON);
      busy_d = (state_d != S_ON) && (state_d != S_OFF);
      done_d = (state_d != state_q) && !busy_d;

`ifdef HEEPSILON_PWR_ACK_TIMEOUT_EN
      if (state_d != state_q) tcnt_d = '0;
      else if (tcnt_q != TW'(ACK_TIMEOUT)) tcnt_d = tcnt_q + TW'(1);
      else tcnt_d = tcnt_q;
      if (bus.err_clr_i[g]) err_d = 1'b0;
      if (tmo) err_d = 1'b1;
`endif
    end

    assign bus.clk_en_o[g]     = pwr_q[3];
    assign bus.iso_o[g]        = pwr_q[2];
    assign bus.subsys_rst_o[g] = pwr_q[1];
    assign bus.sw_on_o[g]      = pwr_q[0];
    assign bus.on_o[g]         = on_q;
    assign bus.busy_o[g]       = busy_q;
    assign bus.done_o[g]       = done_q;
    assign bus.err_o[g]        = err_q;
    assign done_d_v[g]         = done_d;
    assign err_d_v[g]          = err_d;
    assign err_q_v[g]          = err_q;
  end

`ifndef HEEPSILON_PWR_ACK_TIMEOUT_EN
  logic unused_cfg;
  assign unused_cfg = ^{bus.err_clr_i, 32'(ACK_TIMEOUT)};
`endif

  // Interrupt aligned with done_o and with the cycle err_o rises
  always_ff @(posedge clk_i) begin
    if (rst_i) irq_q <= 1'b0;
    else       irq_q <= (|done_d_v) | (|(err_d_v & ~err_q_v));
  end

  assign bus.irq_o = irq_q;
endmodule
